// File: rtl/hdlc_pkg.sv
// Shared HDLC transmit types and line patterns.
// The FCS state only exists when HDLC_TX_FCS_EN is defined.
package hdlc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START_FLAG,
        DATA,
`ifdef HDLC_TX_FCS_EN
        FCS,
`endif
        END_FLAG,
        ABORT
    } tx_state_t;

    localparam logic [7:0]  FLAG_PATTERN  = 8'h7E;
    // Sent LSB first: a single 0 followed by seven 1s.
    localparam logic [7:0]  ABORT_PATTERN = 8'hFE;
    localparam logic [15:0] CRC_POLY      = 16'h8408;
    localparam logic [15:0] CRC_INIT      = 16'hFFFF;

endpackage

// File: rtl/hdlc_tx_framer_if.sv
// Tx buffer handshake between the transmit controller (master) and the framer (slave).
interface hdlc_tx_framer_if;

    logic       Tx_ValidFrame;
    logic       Tx_DataValid;
    logic [7:0] Tx_Data;
    logic       Tx_AbortFrame;
    logic       Tx_RdBuff;

    modport master (
        output Tx_ValidFrame, Tx_DataValid, Tx_Data, Tx_AbortFrame,
        input  Tx_RdBuff
    );

    modport slave (
        input  Tx_ValidFrame, Tx_DataValid, Tx_Data, Tx_AbortFrame,
        output Tx_RdBuff
    );

endinterface

// File: rtl/hdlc_tx_crc16.sv
// Bit-serial CRC-16/X.25 (reflected), fed one unstuffed payload bit per enable.
module hdlc_tx_crc16
    import hdlc_pkg::*;
(
    input  logic        Clk,
    input  logic        clear,
    input  logic        enable,
    input  logic        bitIn,
    output logic [15:0] crc
);

    logic feedback;

    assign feedback = crc[0] ^ bitIn;

    always_ff @(posedge Clk) begin
        if (clear) begin
            crc <= CRC_INIT;
        end else if (enable) begin
            crc <= (crc >> 1) ^ (feedback ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/hdlc_tx_framer.sv
// HDLC transmit framer: flags, zero insertion, abort pattern and idle fill, one bit per Clk.
// Define HDLC_TX_FCS_EN to append the complemented CRC-16/X.25 after the payload.
module hdlc_tx_framer
    import hdlc_pkg::*;
#(
    parameter int MAX_BYTES   = 128,
    parameter int STUFF_LIMIT = 5
) (
    input  logic            Clk,
    input  logic            Rst,
    hdlc_tx_framer_if.slave txIf,
    output logic            Tx,
    output logic            Tx_Busy,
    output logic            Tx_Done,
    output logic            Tx_AbortedTrans
);

    localparam int BYTE_W = $clog2(MAX_BYTES + 1);
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [BYTE_W-1:0] BYTE_MAX = BYTE_W'(MAX_BYTES);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);

    tx_state_t         state;
    logic [3:0]        bitCnt;
    logic [ONES_W-1:0] onesCnt;
    logic [BYTE_W-1:0] byteCnt;
    logic              stuffing;
    logic [7:0]        dataReg;

    logic stuffDue, abortReq, byteEnd, loadByte, dataBit;

    function automatic logic [ONES_W-1:0] nextOnes(logic [ONES_W-1:0] ones, logic b);
        return b ? ones + ONES_W'(1) : '0;
    endfunction

    // byteEnd marks the last driven cycle of a flag or byte, including a trailing stuffed 0.
    always_comb begin
        stuffDue = !stuffing && (onesCnt == ONES_MAX);
        abortReq = 1'b0;
        byteEnd  = 1'b0;
        dataBit  = dataReg[bitCnt[2:0] + 3'd1];
        case (state)
            START_FLAG: begin
                abortReq = txIf.Tx_AbortFrame;
                byteEnd  = (bitCnt == 4'd7);
            end
            DATA: begin
                abortReq = txIf.Tx_AbortFrame;
                byteEnd  = (bitCnt == 4'd7) && !stuffDue;
            end
`ifdef HDLC_TX_FCS_EN
            FCS: abortReq = txIf.Tx_AbortFrame;
`endif
            default: ;
        endcase
        loadByte = byteEnd && !abortReq && txIf.Tx_ValidFrame && txIf.Tx_DataValid &&
                   (byteCnt < BYTE_MAX);
    end

    assign txIf.Tx_RdBuff = loadByte;

`ifdef HDLC_TX_FCS_EN
    logic [15:0] crc;
    logic [15:0] fcsReg;
    logic        crcClr, crcEn, crcBit, fcsBit;

    assign crcClr = (state == IDLE) && txIf.Tx_ValidFrame;
    assign crcEn  = loadByte || ((state == DATA) && !byteEnd && !stuffDue && !abortReq);
    assign crcBit = loadByte ? txIf.Tx_Data[0] : dataBit;
    assign fcsBit = fcsReg[bitCnt + 4'd1];

    hdlc_tx_crc16 u_crc (
        .Clk    (Clk),
        .clear  (crcClr),
        .enable (crcEn),
        .bitIn  (crcBit),
        .crc    (crc)
    );
`endif

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state           <= IDLE;
            Tx              <= 1'b1;
            Tx_Busy         <= 1'b0;
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            bitCnt          <= '0;
            onesCnt         <= '0;
            byteCnt         <= '0;
            stuffing        <= 1'b0;
        end else begin
            Tx_Done         <= 1'b0;
            Tx_AbortedTrans <= 1'b0;
            // Abort request, underrun and overflow all start the abort pattern.
            if (abortReq || (byteEnd && txIf.Tx_ValidFrame && !loadByte)) begin
                state           <= ABORT;
                Tx              <= ABORT_PATTERN[0];
                bitCnt          <= '0;
                onesCnt         <= '0;
                stuffing        <= 1'b0;
                Tx_AbortedTrans <= 1'b1;
            end else if (loadByte) begin
                state    <= DATA;
                dataReg  <= txIf.Tx_Data;
                Tx       <= txIf.Tx_Data[0];
                bitCnt   <= '0;
                onesCnt  <= nextOnes(onesCnt, txIf.Tx_Data[0]);
                stuffing <= 1'b0;
                byteCnt  <= byteCnt + BYTE_W'(1);
            end else if (byteEnd) begin
`ifdef HDLC_TX_FCS_EN
                state    <= FCS;
                fcsReg   <= ~crc;
                Tx       <= ~crc[0];
                bitCnt   <= '0;
                onesCnt  <= nextOnes(onesCnt, ~crc[0]);
                stuffing <= 1'b0;
`else
                state    <= END_FLAG;
                Tx       <= FLAG_PATTERN[0];
                bitCnt   <= '0;
                onesCnt  <= '0;
                stuffing <= 1'b0;
`endif
            end else begin
                case (state)
                    IDLE: begin
                        Tx      <= 1'b1;
                        byteCnt <= '0;
                        if (txIf.Tx_ValidFrame) begin
                            state   <= START_FLAG;
                            Tx      <= FLAG_PATTERN[0];
                            bitCnt  <= '0;
                            onesCnt <= '0;
                            Tx_Busy <= 1'b1;
                        end
                    end
                    START_FLAG: begin
                        bitCnt <= bitCnt + 4'd1;
                        Tx     <= FLAG_PATTERN[bitCnt[2:0] + 3'd1];
                    end
                    DATA: begin
                        if (stuffDue) begin
                            Tx       <= 1'b0;
                            stuffing <= 1'b1;
                            onesCnt  <= '0;
                        end else begin
                            bitCnt   <= bitCnt + 4'd1;
                            Tx       <= dataBit;
                            onesCnt  <= nextOnes(onesCnt, dataBit);
                            stuffing <= 1'b0;
                        end
                    end
`ifdef HDLC_TX_FCS_EN
                    FCS: begin
                        if (stuffDue) begin
                            Tx       <= 1'b0;
                            stuffing <= 1'b1;
                            onesCnt  <= '0;
                        end else if (bitCnt == 4'd15) begin
                            state    <= END_FLAG;
                            Tx       <= FLAG_PATTERN[0];
                            bitCnt   <= '0;
                            onesCnt  <= '0;
                            stuffing <= 1'b0;
                        end else begin
                            bitCnt   <= bitCnt + 4'd1;
                            Tx       <= fcsBit;
                            onesCnt  <= nextOnes(onesCnt, fcsBit);
                            stuffing <= 1'b0;
                        end
                    end
`endif
                    END_FLAG: begin
                        if (bitCnt == 4'd7) begin
                            state   <= IDLE;
                            Tx      <= 1'b1;
                            Tx_Busy <= 1'b0;
                            Tx_Done <= 1'b1;
                            byteCnt <= '0;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                            Tx     <= FLAG_PATTERN[bitCnt[2:0] + 3'd1];
                        end
                    end
                    ABORT: begin
                        if (bitCnt == 4'd7) begin
                            state   <= IDLE;
                            Tx      <= 1'b1;
                            Tx_Busy <= 1'b0;
                            byteCnt <= '0;
                        end else begin
                            bitCnt <= bitCnt + 4'd1;
                            Tx     <= ABORT_PATTERN[bitCnt[2:0] + 3'd1];
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
